// File: rtl/common.sv
// Shared constants for the RV32I -> RVC instruction packer: opcodes, widths,
// pad halfword and the packer state type.
package common;

  localparam int INSTRUCTION_WIDTH = 32;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;

  localparam logic [15:0] C_NOP = 16'h0001;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_t;

  // True for x8..x15, the registers reachable from 3-bit RVC register fields.
  function automatic logic is_rvc_reg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

endpackage

// File: rtl/rvc_encoder.sv
// Combinational RV32I -> RVC encoder. Only forms whose immediates are
// non-negative are produced, so expansion gives back the original bits.
module rvc_encoder
  import common::*;
(
  input  logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic                         is_compressible,
  output logic [15:0]                  c_instr
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [11:0] imm_i;
  logic [11:0] imm_s;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign imm_i  = instr[31:20];
  assign imm_s  = {instr[31:25], instr[11:7]};

  always_comb begin
    is_compressible = 1'b0;
    c_instr         = 16'h0000;
    case (opcode)
      LOAD: begin
        if (funct3 == 3'b010 && is_rvc_reg(rd) && is_rvc_reg(rs1) &&
            imm_i[1:0] == 2'b00 && imm_i[11:7] == 5'd0) begin
          is_compressible = 1'b1;
          c_instr = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end
      end
      STORE: begin
        if (funct3 == 3'b010 && is_rvc_reg(rs2) && is_rvc_reg(rs1) &&
            imm_s[1:0] == 2'b00 && imm_s[11:7] == 5'd0) begin
          is_compressible = 1'b1;
          c_instr = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        end
      end
      OP_IMM: begin
        case (funct3)
          3'b000: begin
            if (rd == rs1 && rd != 5'd0 && imm_i[11:5] == 7'd0 && imm_i[4:0] != 5'd0) begin
              is_compressible = 1'b1;
              c_instr = {3'b000, 1'b0, rd, imm_i[4:0], 2'b01};
            end else if (rs1 == 5'd0 && rd != 5'd0 && imm_i[11:5] == 7'd0) begin
              is_compressible = 1'b1;
              c_instr = {3'b010, 1'b0, rd, imm_i[4:0], 2'b01};
            end
          end
          3'b001: begin
            if (funct7 == 7'd0 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
              is_compressible = 1'b1;
              c_instr = {3'b000, 1'b0, rd, rs2, 2'b10};
            end
          end
          3'b101: begin
            // funct7[5] separates SRAI from SRLI in both encodings.
            if ((funct7 == 7'b0000000 || funct7 == 7'b0100000) &&
                rd == rs1 && is_rvc_reg(rd) && rs2 != 5'd0) begin
              is_compressible = 1'b1;
              c_instr = {3'b100, 1'b0, 1'b0, funct7[5], rd[2:0], rs2, 2'b01};
            end
          end
          3'b111: begin
            if (rd == rs1 && is_rvc_reg(rd) && imm_i[11:5] == 7'd0) begin
              is_compressible = 1'b1;
              c_instr = {3'b100, 1'b0, 2'b10, rd[2:0], imm_i[4:0], 2'b01};
            end
          end
          default: ;
        endcase
      end
      LUI: begin
        if (rd != 5'd0 && rd != 5'd2 && instr[31:18] == 14'd0 && instr[17:12] != 6'd0) begin
          is_compressible = 1'b1;
          c_instr = {3'b011, instr[17], rd, instr[16:12], 2'b01};
        end
      end
      OP: begin
        if (funct7 == 7'd0 && funct3 == 3'b000 && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0) begin
          is_compressible = 1'b1;
          c_instr = {3'b100, 1'b0, rd, rs2, 2'b10};
        end else if (funct7 == 7'd0 && funct3 == 3'b000 && rd == rs1 && rd != 5'd0 &&
                     rs2 != 5'd0) begin
          is_compressible = 1'b1;
          c_instr = {3'b100, 1'b1, rd, rs2, 2'b10};
        end else if (rd == rs1 && is_rvc_reg(rd) && is_rvc_reg(rs2)) begin
          if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
            is_compressible = 1'b1;
            c_instr = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b00, rs2[2:0], 2'b01};
          end else if (funct7 == 7'd0 && funct3 == 3'b100) begin
            is_compressible = 1'b1;
            c_instr = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b01, rs2[2:0], 2'b01};
          end else if (funct7 == 7'd0 && funct3 == 3'b110) begin
            is_compressible = 1'b1;
            c_instr = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b10, rs2[2:0], 2'b01};
          end else if (funct7 == 7'd0 && funct3 == 3'b111) begin
            is_compressible = 1'b1;
            c_instr = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b11, rs2[2:0], 2'b01};
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rvc_packer.sv
// Packs a stream of RV32I instructions, compressed where possible, into
// little-endian 32-bit memory words with a one-deep output register.
module rvc_packer
  import common::*;
#(
  parameter int COMPRESS_EN = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instr,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_word,
  output logic                         empty,
  output logic [15:0]                  comp_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; out_word is held stable while out_valid && !out_ready.

  pack_state_t                  state, state_nxt;
  logic [15:0]                  p, p_nxt;
  logic [INSTRUCTION_WIDTH-1:0] out_word_nxt;
  logic                         out_valid_nxt;
  logic [15:0]                  comp_cnt_nxt;

  logic                         enc_ok;
  logic [15:0]                  enc_c;
  logic                         slot_free;
  logic                         accept;
  logic                         use_c;

  rvc_encoder u_encoder (
    .instr          (in_instr),
    .is_compressible(enc_ok),
    .c_instr        (enc_c)
  );

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !flush;
  assign accept    = in_valid && in_ready;
  assign use_c     = (COMPRESS_EN != 0) && enc_ok;
  assign empty     = (state == EMPTY) && !out_valid;

  always_comb begin
    state_nxt     = state;
    p_nxt         = p;
    out_word_nxt  = out_word;
    out_valid_nxt = out_valid;
    comp_cnt_nxt  = comp_cnt;

    if (out_valid && out_ready) out_valid_nxt = 1'b0;

    if (accept) begin
      out_valid_nxt = (state == HALF) || !use_c;
      if (use_c) begin
        if (comp_cnt != 16'hFFFF) comp_cnt_nxt = comp_cnt + 16'd1;
        if (state == EMPTY) begin
          p_nxt     = enc_c;
          state_nxt = HALF;
        end else begin
          out_word_nxt = {enc_c, p};
          state_nxt    = EMPTY;
        end
      end else if (state == EMPTY) begin
        out_word_nxt = in_instr;
      end else begin
        // A 32-bit instruction straddles the word boundary; its upper half waits.
        out_word_nxt = {in_instr[15:0], p};
        p_nxt        = in_instr[31:16];
      end
    end else if (flush && slot_free && state == HALF) begin
      out_word_nxt  = {C_NOP, p};
      out_valid_nxt = 1'b1;
      state_nxt     = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      p         <= 16'h0000;
      out_word  <= '0;
      out_valid <= 1'b0;
      comp_cnt  <= 16'h0000;
    end else begin
      state     <= state_nxt;
      p         <= p_nxt;
      out_word  <= out_word_nxt;
      out_valid <= out_valid_nxt;
      comp_cnt  <= comp_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rvc_packer.sv
// Bench for rvc_packer: a halfword-stream model predicts every emitted word,
// with directed sequences and literal expectations around it.
module tb_rvc_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        empty;
  logic [15:0] comp_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] hq[$];
  logic [31:0] exp_q[$];
  int          exp_cnt = 0;

  always #5 clk = ~clk;

  rvc_packer #(.COMPRESS_EN(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .empty    (empty),
    .comp_cnt (comp_cnt)
  );

  // ---------------- model: RVC formats assembled arithmetically ----------------
  function automatic bit creg(input int r);
    return r >= 8 && r <= 15;
  endfunction

  function automatic logic [15:0] ci(input int f, input int b12, input int r, input int lo, input int q);
    return 16'((f << 13) | (b12 << 12) | (r << 7) | (lo << 2) | q);
  endfunction

  function automatic logic [15:0] cl(input int f, input int uimm, input int rb, input int rr);
    return 16'((f << 13) | (((uimm >> 3) & 7) << 10) | ((rb - 8) << 7) |
               (((uimm >> 2) & 1) << 6) | (((uimm >> 6) & 1) << 5) | ((rr - 8) << 2));
  endfunction

  function automatic logic [15:0] cb(input int sub, input int r, input int lo);
    return 16'((4 << 13) | (sub << 10) | ((r - 8) << 7) | (lo << 2) | 1);
  endfunction

  function automatic logic [15:0] ca(input int sel, input int r, input int r2);
    return 16'((4 << 13) | (3 << 10) | ((r - 8) << 7) | (sel << 5) | ((r2 - 8) << 2) | 1);
  endfunction

  function automatic logic [15:0] cr(input int f4, input int r, input int r2);
    return 16'((f4 << 12) | (r << 7) | (r2 << 2) | 2);
  endfunction

  // Returns {compressible, c_form}.
  function automatic logic [16:0] model_enc(input logic [31:0] i);
    int op, rd, f3, rs1, rs2, f7, imm, simm, u;
    op   = int'(i[6:0]);
    rd   = int'(i[11:7]);
    f3   = int'(i[14:12]);
    rs1  = int'(i[19:15]);
    rs2  = int'(i[24:20]);
    f7   = int'(i[31:25]);
    imm  = int'($signed(i[31:20]));
    simm = int'($signed({i[31:25], i[11:7]}));
    u    = int'(i[31:12]);
    if (op == 3 && f3 == 2 && creg(rd) && creg(rs1) && imm >= 0 && imm <= 124 && imm % 4 == 0)
      return {1'b1, cl(2, imm, rs1, rd)};
    if (op == 35 && f3 == 2 && creg(rs2) && creg(rs1) && simm >= 0 && simm <= 124 && simm % 4 == 0)
      return {1'b1, cl(6, simm, rs1, rs2)};
    if (op == 19 && f3 == 0 && rd == rs1 && rd != 0 && imm >= 1 && imm <= 31)
      return {1'b1, ci(0, 0, rd, imm, 1)};
    if (op == 19 && f3 == 0 && rs1 == 0 && rd != 0 && imm >= 0 && imm <= 31)
      return {1'b1, ci(2, 0, rd, imm, 1)};
    if (op == 55 && rd != 0 && rd != 2 && u >= 1 && u <= 63)
      return {1'b1, ci(3, u >> 5, rd, u & 31, 1)};
    if (op == 19 && f3 == 1 && f7 == 0 && rd == rs1 && rd != 0 && rs2 != 0)
      return {1'b1, ci(0, 0, rd, rs2, 2)};
    if (op == 19 && f3 == 5 && (f7 == 0 || f7 == 32) && rd == rs1 && creg(rd) && rs2 != 0)
      return {1'b1, cb((f7 == 32) ? 1 : 0, rd, rs2)};
    if (op == 19 && f3 == 7 && rd == rs1 && creg(rd) && imm >= 0 && imm <= 31)
      return {1'b1, cb(2, rd, imm)};
    if (op == 51 && f7 == 0 && f3 == 0 && rs1 == 0 && rd != 0 && rs2 != 0)
      return {1'b1, cr(8, rd, rs2)};
    if (op == 51 && f7 == 0 && f3 == 0 && rd == rs1 && rd != 0 && rs2 != 0)
      return {1'b1, cr(9, rd, rs2)};
    if (op == 51 && rd == rs1 && creg(rd) && creg(rs2)) begin
      if (f7 == 32 && f3 == 0) return {1'b1, ca(0, rd, rs2)};
      if (f7 == 0 && f3 == 4) return {1'b1, ca(1, rd, rs2)};
      if (f7 == 0 && f3 == 6) return {1'b1, ca(2, rd, rs2)};
      if (f7 == 0 && f3 == 7) return {1'b1, ca(3, rd, rs2)};
    end
    return 17'd0;
  endfunction

  task automatic model_accept(input logic [31:0] i);
    logic [16:0] m;
    logic [15:0] lo, hi;
    m = model_enc(i);
    if (m[16]) begin
      hq.push_back(m[15:0]);
      if (exp_cnt < 65535) exp_cnt++;
    end else begin
      hq.push_back(i[15:0]);
      hq.push_back(i[31:16]);
    end
    while (hq.size() >= 2) begin
      lo = hq.pop_front();
      hi = hq.pop_front();
      exp_q.push_back({hi, lo});
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'((!out_valid || out_ready) && !flush));
      chk("comp_cnt", 32'(comp_cnt), 32'(exp_cnt));
      chk("empty", 32'(empty), 32'(hq.size() == 0 && exp_q.size() == 0));
      chk("no_spurious_word", 32'(out_valid && exp_q.size() == 0), 32'd0);
      if (out_valid && out_ready && exp_q.size() != 0)
        chk("out_word_stream", out_word, exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    sync();
    hq.delete();
    exp_q.delete();
    exp_cnt = 0;
    rst_n   = 1'b1;
  endtask

  task automatic send(input logic [31:0] i);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_instr = i;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (got) begin
      sync();
      model_accept(i);
    end else begin
      chk("send_timeout", 32'd1, 32'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    bit free;
    logic [15:0] lo;
    if (hq.size() == 1) begin
      lo = hq.pop_front();
      exp_q.push_back({16'h0001, lo});
    end
    free  = 1'b0;
    flush = 1'b1;
    for (int n = 0; n < 50 && !free; n++) begin
      @(negedge clk);
      if (!out_valid || out_ready) free = 1'b1;
    end
    if (!free) chk("flush_timeout", 32'd1, 32'd0);
    sync();
    flush = 1'b0;
  endtask

  // {instr, expected c form, compressible}
  logic [48:0] table_v[16] = '{
    {32'h00540413, 16'h0415, 1'b1}, {32'h00A484B3, 16'h94AA, 1'b1},
    {32'h07C4A403, 16'h5CE0, 1'b1}, {32'h0804A403, 16'h0000, 1'b0},
    {32'h01F00293, 16'h42FD, 1'b1}, {32'h0001F1B7, 16'h61FD, 1'b1},
    {32'h40940433, 16'h8C05, 1'b1}, {32'h4034D493, 16'h848D, 1'b1},
    {32'h00040413, 16'h0000, 1'b0}, {32'h0001F137, 16'h0000, 1'b0},
    {32'h00942023, 16'hC004, 1'b1}, {32'h006002B3, 16'h829A, 1'b1},
    {32'h00409093, 16'h0092, 1'b1}, {32'h00F57513, 16'h893D, 1'b1},
    {32'hFFF40413, 16'h0000, 1'b0}, {32'h00946433, 16'h8C45, 1'b1}
  };

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [16:0] m;
    logic [31:0] ins;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_comp_cnt", 32'(comp_cnt), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    sync();

    // model pinned against hand-encoded forms
    foreach (table_v[k]) begin
      m = model_enc(table_v[k][48:17]);
      chk("model_enc", 32'(m), 32'({table_v[k][0], table_v[k][16:1]}));
    end

    // two compressed instructions fill one word
    send(32'h00540413);
    send(32'h00A484B3);
    @(negedge clk);
    chk("pair_valid", 32'(out_valid), 32'd1);
    chk("pair_word", out_word, 32'h94AA0415);
    chk("pair_cnt", 32'(comp_cnt), 32'd2);
    sync();

    // negative immediate stays 32-bit, next-cycle output
    reset_dut();
    send(32'hFFF40413);
    @(negedge clk);
    chk("neg_valid", 32'(out_valid), 32'd1);
    chk("neg_word", out_word, 32'hFFF40413);
    chk("neg_cnt", 32'(comp_cnt), 32'd0);
    sync();

    // straddling 32-bit instruction, then flush pads with C.NOP
    reset_dut();
    send(32'h00540413);
    send(32'hFFF40413);
    @(negedge clk);
    chk("straddle_word", out_word, 32'h04130415);
    sync();
    do_flush();
    @(negedge clk);
    chk("flush_valid", 32'(out_valid), 32'd1);
    chk("flush_word", out_word, 32'h0001FFF4);
    sync();
    @(negedge clk);
    chk("flush_empty", 32'(empty), 32'd1);
    sync();

    // flush while empty does nothing
    do_flush();
    @(negedge clk);
    chk("flush_noop_empty", 32'(empty), 32'd1);
    chk("flush_noop_valid", 32'(out_valid), 32'd0);
    sync();

    // backpressure holds the word and blocks input
    out_ready = 1'b0;
    send(32'h0001F137);
    in_valid = 1'b1;
    in_instr = 32'h00040413;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_word", out_word, 32'h0001F137);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    sync();
    out_ready = 1'b1;
    send(32'h00040413);
    @(negedge clk);
    chk("release_word", out_word, 32'h00040413);
    chk("release_valid", 32'(out_valid), 32'd1);
    sync();

    // LW offset boundary: 124 compresses, 128 does not
    reset_dut();
    send(32'h07C4A403);
    send(32'h0804A403);
    @(negedge clk);
    chk("lw_word", out_word, 32'hA4035CE0);
    chk("lw_cnt", 32'(comp_cnt), 32'd1);
    sync();
    do_flush();
    @(negedge clk);
    chk("lw_tail", out_word, 32'h00010804);
    sync();

    // reset in HALF with a word pending discards both
    reset_dut();
    send(32'h00540413);
    out_ready = 1'b0;
    send(32'hFFF40413);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_empty", 32'(empty), 32'd0);
    sync();
    reset_dut();
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_cnt", 32'(comp_cnt), 32'd0);
    sync();
    out_ready = 1'b1;
    send(32'h00A484B3);
    do_flush();
    @(negedge clk);
    chk("post_rst_word", out_word, 32'h000194AA);
    sync();

    // mixed stream with periodic output stalls, checked by the model
    reset_dut();
    foreach (table_v[k]) begin
      if (k % 3 == 2) begin
        out_ready = 1'b0;
        sync();
        sync();
        out_ready = 1'b1;
      end
      ins = table_v[k][48:17];
      send(ins);
    end
    out_ready = 1'b1;
    do_flush();
    repeat (3) sync();
    chk("drained_words", 32'(exp_q.size()), 32'd0);
    chk("drained_halves", 32'(hq.size()), 32'd0);
    chk("drained_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rvc_packer.md
RVC_PACKER -- requirements
Module: rvc_packer

Interface
REQ-001 Parameter COMPRESS_EN, default 1, meaning: 1 enables compression; 0 passes every instruction through as 32 bits.
REQ-002 clk  input  1  sole clock; every register updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  in_instr holds a valid 32-bit RV32I instruction.
REQ-005 in_ready  output  1  block accepts in_instr this cycle.
REQ-006 in_instr  input  INSTRUCTION_WIDTH  uncompressed instruction.
REQ-007 flush  input  1  level request: emit any pending halfword padded with C.NOP.
REQ-008 out_valid  output  1  out_word holds a valid memory word.
REQ-009 out_ready  input  1  consumer accepts out_word this cycle.
REQ-010 out_word  output  INSTRUCTION_WIDTH  packed little-endian memory word; the lower halfword is the earlier one.
REQ-011 empty  output  1  no pending halfword and out_valid=0.
REQ-012 comp_cnt  output  16  count of instructions compressed since reset; saturates at 0xFFFF.

Function
REQ-013 in_ready SHALL equal (!out_valid || out_ready) && !flush; an instruction is accepted when in_valid && in_ready.
REQ-014 The encoder SHALL produce a 16-bit form only for these cases; all other instructions SHALL remain 32-bit:
  - LW: rd and rs1 in x8–x15; imm[1:0]=0; imm[11:7]=0 -> C.LW.
  - SW: rs1 and rs2 in x8–x15; imm[1:0]=0; imm[11:7]=0 -> C.SW.
  - ADDI: rd=rs1≠x0; imm in 1..31 -> C.ADDI.
  - ADDI: rs1=x0; rd≠x0; imm in 0..31 -> C.LI.
  - LUI: rd∉{x0,x2}; imm[31:18]=0; imm[17:12]≠0 -> C.LUI.
  - SLLI: rd=rs1≠x0; shamt≠0 -> C.SLLI.
  - SRLI and SRAI: rd=rs1 in x8–x15; shamt≠0 -> C.SRLI and C.SRAI.
  - ANDI: rd=rs1 in x8–x15; imm in 0..31 -> C.ANDI.
  - ADD: rs1=x0; rd≠x0; rs2≠x0 -> C.MV.
  - ADD: rd=rs1≠x0; rs2≠x0 -> C.ADD.
  - SUB, XOR, OR, AND: rd=rs1 in x8–x15; rs2 in x8–x15 -> C.SUB, C.XOR, C.OR, C.AND.
REQ-015 Immediates SHALL be restricted to non-negative ranges as listed, so that the team's expander reproduces the original instruction bit-exactly.
REQ-016 Packing SHALL use two states: EMPTY (no pending halfword) and HALF (16-bit pending register p).
REQ-017 Accepted instruction, EMPTY state:
  - compressed c: p<=c; go to HALF; no output.
  - 32-bit i: out_word<=i; stay in EMPTY.
REQ-018 Accepted instruction, HALF state:
  - compressed c: out_word<={c,p}; go to EMPTY.
  - 32-bit i: out_word<={i[15:0],p}; p<=i[31:16]; stay in HALF.
REQ-019 Flush in HALF with the output slot free (!out_valid || out_ready): out_word<={16'h0001,p}; go to EMPTY. Flush in EMPTY SHALL be a no-op.
REQ-020 Latency: out_valid SHALL assert in the cycle after the producing acceptance or flush; throughput is one instruction per cycle.
REQ-021 While out_valid && !out_ready, out_word SHALL be held stable.
REQ-022 out_valid SHALL clear on a handshake unless a new word is loaded in the same cycle.
REQ-023 comp_cnt SHALL increment by 1 per accepted compressed instruction, holding at 0xFFFF.
REQ-024 With COMPRESS_EN=0, the state SHALL remain EMPTY and comp_cnt SHALL remain 0.

Reset
REQ-025 While rst_n=0 at a clock edge, the following SHALL hold; reset mid-operation SHALL discard any pending halfword and undelivered word:
  - state: EMPTY.
  - p, out_word: 0.
  - out_valid: 0.
  - comp_cnt: 0.
  - empty: 1.
  - in_ready: per REQ-013.

Structure
REQ-026 Package common SHALL hold INSTRUCTION_WIDTH, the opcodes LOAD, STORE, OP, OP_IMM, LUI, and the constant C_NOP=16'h0001.
REQ-027 The combinational encoder SHALL be sub-module rvc_encoder, with outputs is_compressible and c_instr[15:0]; rvc_packer holds all sequential logic.

Verification
REQ-028 ADDI x8,x8,5 (0x00540413) then ADD x9,x9,x10 (0x00A484B3) -> one word 0x94AA0415; comp_cnt=2.
REQ-029 ADDI x8,x8,-1 (0xFFF40413) from EMPTY -> out_word=0xFFF40413 in the next cycle; comp_cnt=0.
REQ-030 0x00540413, then 0xFFF40413, then flush -> words 0x04130415 and 0x0001FFF4; empty=1 afterwards.
REQ-031 out_ready=0 for 5 cycles with out_valid=1 -> out_word stable and in_ready=0; on release the next word follows with no loss.
REQ-032 Boundary: LW x8,124(x9) -> 16-bit C.LW; LW x8,128(x9) -> passes 32-bit.
REQ-033 rst_n=0 in HALF with out_valid=1 -> following cycle out_valid=0, empty=1, comp_cnt=0; the pending halfword is never emitted.
